hyper_arb: RTL and testbench

HYPER_ARB -- requirements
Module: hyper_arb

---
 rtl/hyper_arb.sv | 155 +++++++++++++++
 tb/tb_hyper_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_arb.sv
// hyper_arb: two-port arbiter issuing single-dword read/write commands to hyper_xface.
// Each transaction is latched at grant time and held until its one-cycle ack.
// A missing busy response is bounded by TIMEOUT_CYC and flagged in a sticky error bit.
// Build option: define HYPER_ARB_RR_EN to use round-robin arbitration. Without it,
// arbitration is fixed priority with port 0 first.
module hyper_arb #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_reg,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wr_d,
  input  logic [3:0]  p0_be,
  output logic        p0_ack,
  output logic [31:0] p0_rd_d,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_reg,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wr_d,
  input  logic [3:0]  p1_be,
  output logic        p1_ack,
  output logic [31:0] p1_rd_d,
  output logic        rd_req,
  output logic        wr_req,
  output logic        mem_or_reg,
  output logic [3:0]  wr_byte_en,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic [5:0]  rd_num_dwords,
  input  logic        busy,
  input  logic        rd_rdy,
  input  logic [31:0] rd_d,
  output logic        grant,
  output logic        timeout_err
);

  localparam int unsigned NDW  = 6;
  localparam int unsigned CNTW = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t          state;
  logic            cmd_we;
  logic [CNTW-1:0] to_cnt;
  logic            win_c;
`ifdef HYPER_ARB_RR_EN
  logic            last_grant;
`endif

  // Winner among the current requesters; only consulted in IDLE with a request pending
  always_comb begin
    win_c = 1'b0;
`ifdef HYPER_ARB_RR_EN
    if (p0_req && p1_req) win_c = ~last_grant;
    else                  win_c = p1_req;
`else
    win_c = ~p0_req;
`endif
  end

  // Transaction sequencer with registered command, ack and read-data outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_we        <= 1'b0;
      to_cnt        <= '0;
      rd_req        <= 1'b0;
      wr_req        <= 1'b0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      p0_rd_d       <= '0;
      p1_rd_d       <= '0;
      addr          <= '0;
      wr_d          <= '0;
      wr_byte_en    <= '0;
      mem_or_reg    <= 1'b0;
      rd_num_dwords <= NDW'(1);
      grant         <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef HYPER_ARB_RR_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      rd_req <= 1'b0;
      wr_req <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant <= win_c;
`ifdef HYPER_ARB_RR_EN
            last_grant <= win_c;
`endif
            if (win_c) begin
              cmd_we     <= p1_we;
              wr_req     <= p1_we;
              rd_req     <= ~p1_we;
              mem_or_reg <= p1_reg;
              addr       <= p1_addr;
              wr_d       <= p1_wr_d;
              wr_byte_en <= p1_be;
            end else begin
              cmd_we     <= p0_we;
              wr_req     <= p0_we;
              rd_req     <= ~p0_we;
              mem_or_reg <= p0_reg;
              addr       <= p0_addr;
              wr_d       <= p0_wr_d;
              wr_byte_en <= p0_be;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (rd_rdy && !cmd_we) begin
            if (grant) p1_rd_d <= rd_d;
            else       p0_rd_d <= rd_d;
          end
          if (state == WAIT_BUSY) begin
            if (busy) begin
              state <= WAIT_DONE;
            end else if (to_cnt == CNTW'(TIMEOUT_CYC - 1)) begin
              timeout_err <= 1'b1;
              p0_ack      <= ~grant;
              p1_ack      <= grant;
              state       <= DONE;
            end else begin
              to_cnt <= to_cnt + CNTW'(1);
            end
          end else if (!busy) begin
            p0_ack <= ~grant;
            p1_ack <= grant;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_arb.sv
// tb_hyper_arb: randomized scoreboard bench for hyper_arb.
// A transaction-level model orders the queued requests, a hyper_xface responder plays
// back a busy/rd_rdy plan for each command, and a monitor checks commands and acks.
`timescale 1ns/1ps
module tb_hyper_arb;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_reg, p0_ack;
  logic [31:0] p0_addr, p0_wr_d, p0_rd_d;
  logic [3:0]  p0_be;
  logic        p1_req, p1_we, p1_reg, p1_ack;
  logic [31:0] p1_addr, p1_wr_d, p1_rd_d;
  logic [3:0]  p1_be;
  logic        rd_req, wr_req, mem_or_reg, busy, rd_rdy, grant, timeout_err;
  logic [3:0]  wr_byte_en;
  logic [31:0] addr, wr_d, rd_d;
  logic [5:0]  rd_num_dwords;

  hyper_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_reg(p0_reg), .p0_addr(p0_addr),
    .p0_wr_d(p0_wr_d), .p0_be(p0_be), .p0_ack(p0_ack), .p0_rd_d(p0_rd_d),
    .p1_req(p1_req), .p1_we(p1_we), .p1_reg(p1_reg), .p1_addr(p1_addr),
    .p1_wr_d(p1_wr_d), .p1_be(p1_be), .p1_ack(p1_ack), .p1_rd_d(p1_rd_d),
    .rd_req(rd_req), .wr_req(wr_req), .mem_or_reg(mem_or_reg),
    .wr_byte_en(wr_byte_en), .addr(addr), .wr_d(wr_d),
    .rd_num_dwords(rd_num_dwords), .busy(busy), .rd_rdy(rd_rdy), .rd_d(rd_d),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          we;
    bit          rg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          d;       // idle cycles before busy rises
    int          h;       // cycles busy stays high
    int          r;       // busy cycle carrying rd_rdy
    bit          tmo;     // responder never raises busy
    logic [31:0] rdat;
    bit          exp_te;
    logic [31:0] exp_rd;
  } txn_t;

  txn_t s0[$], s1[$];          // staging for the next batch
  txn_t p0_q[$], p1_q[$];      // payloads the requesters still have to issue
  txn_t exp_q[$];              // expected commands in grant order
  txn_t plan_q[$];             // responder plans in the same order

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_infl = 1'b0;
  bit          last_m = 1'b1;
  bit          te_m = 1'b0;
  logic [31:0] rd_m [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit we, input bit rg, input logic [31:0] a,
                              input logic [31:0] dat, input logic [3:0] be,
                              input int d, input int h, input bit tmo,
                              input logic [31:0] rdat);
    txn_t t;
    t.port = 1'b0; t.we = we; t.rg = rg; t.addr = a; t.data = dat; t.be = be;
    t.d = d; t.h = h; t.r = 0; t.tmo = tmo; t.rdat = rdat;
    t.exp_te = 1'b0; t.exp_rd = '0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int h;
    h = $urandom_range(1, 6);
    t = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 3), h,
           ($urandom_range(0, 9) == 0), $urandom);
    t.r = $urandom_range(0, h - 1);
    return t;
  endfunction

  // Requesters with pending work are always present at the next arbitration point
  task automatic run_batch();
    int i0 = 0;
    int i1 = 0;
    bit w;
    txn_t t;
    while (i0 < s0.size() || i1 < s1.size()) begin
      if (i0 < s0.size() && i1 < s1.size()) begin
`ifdef HYPER_ARB_RR_EN
        w = ~last_m;
`else
        w = 1'b0;
`endif
      end else begin
        w = (i1 < s1.size());
      end
      last_m = w;
      if (w) begin t = s1[i1]; i1++; end
      else   begin t = s0[i0]; i0++; end
      t.port = w;
      if (t.tmo) te_m = 1'b1;
      if (!t.we && !t.tmo) rd_m[w] = t.rdat;
      t.exp_te = te_m;
      t.exp_rd = rd_m[w];
      exp_q.push_back(t);
      plan_q.push_back(t);
    end
    p0_q = s0;
    p1_q = s1;
    s0.delete();
    s1.delete();
    wait_done();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() > 0 || mon_infl || p0_q.size() > 0 || p1_q.size() > 0 ||
            p0_req || p1_req) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("batch_done", 32'(n < 3000), 32'd1);
    if (n >= 3000) begin
      exp_q.delete(); plan_q.delete(); p0_q.delete(); p1_q.delete();
    end
  endtask

  task automatic drive(input bit p, input bit rq, input txn_t t);
    if (p) begin
      p1_req = rq; p1_we = t.we; p1_reg = t.rg; p1_addr = t.addr; p1_wr_d = t.data; p1_be = t.be;
    end else begin
      p0_req = rq; p0_we = t.we; p0_reg = t.rg; p0_addr = t.addr; p0_wr_d = t.data; p0_be = t.be;
    end
  endtask

  // Requester: raise req with a payload, hold it until ack, drop it, re-raise a cycle later
  task automatic port_proc(input bit p);
    txn_t t;
    int n;
    bit ak;
    t = mk(0, 0, '0, '0, '0, 0, 1, 0, '0);
    drive(p, 1'b0, t);
    forever begin
      @(negedge clk);
      if ((p ? p1_q.size() : p0_q.size()) > 0) begin
        if (p) t = p1_q.pop_front();
        else   t = p0_q.pop_front();
        drive(p, 1'b1, t);
        n = 0;
        do begin
          @(negedge clk);
          n++;
          ak = p ? p1_ack : p0_ack;
        end while (!ak && n < 200);
        if (!ak) chk(p ? "p1_ack_wait" : "p0_ack_wait", 32'd0, 32'd1);
        drive(p, 1'b0, t);
      end
    end
  endtask

  initial port_proc(1'b0);
  initial port_proc(1'b1);

  // hyper_xface stand-in: replays the busy/rd_rdy plan of each command, abandons it on reset
  initial begin : xface
    txn_t t;
    bit ab;
    busy = 1'b0; rd_rdy = 1'b0; rd_d = '0;
    forever begin
      @(negedge clk);
      if (!reset && (wr_req || rd_req) && plan_q.size() > 0) begin
        t = plan_q.pop_front();
        ab = 1'b0;
        if (!t.tmo) begin
          for (int k = 0; k <= t.d && !ab; k++) begin
            @(negedge clk);
            ab = reset;
          end
          for (int j = 0; j < t.h && !ab; j++) begin
            busy   = 1'b1;
            rd_rdy = (j == t.r);
            rd_d   = (j == t.r) ? t.rdat : 32'h0;
            @(negedge clk);
            ab = reset;
          end
          busy = 1'b0; rd_rdy = 1'b0; rd_d = '0;
        end
      end
    end
  end

  // Monitor: checks each command against the scoreboard and each ack against its command
  initial begin : monitor
    txn_t cur;
    int   ccyc;
    ccyc = 0;
    cur = mk(0, 0, '0, '0, '0, 0, 1, 0, '0);
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mon_infl = 1'b0;
      end else begin
        if (wr_req || rd_req) begin
          chk("cmd_overlap", 32'(mon_infl), 32'd0);
          if (exp_q.size() == 0) begin
            chk("cmd_unexpected", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            mon_infl = 1'b1;
            ccyc = cyc;
            chk("cmd_grant", 32'(grant), 32'(cur.port));
            chk("cmd_wr_req", 32'(wr_req), 32'(cur.we));
            chk("cmd_rd_req", 32'(rd_req), 32'(!cur.we));
            chk("cmd_addr", addr, cur.addr);
            chk("cmd_wr_d", wr_d, cur.data);
            chk("cmd_be", 32'(wr_byte_en), 32'(cur.be));
            chk("cmd_mem_or_reg", 32'(mem_or_reg), 32'(cur.rg));
            chk("cmd_rd_num_dwords", 32'(rd_num_dwords), 32'd1);
          end
        end
        if (p0_ack || p1_ack) begin
          if (!mon_infl) begin
            chk("ack_unexpected", {30'd0, p1_ack, p0_ack}, 32'd0);
          end else begin
            mon_infl = 1'b0;
            chk("ack_port", {30'd0, p1_ack, p0_ack}, cur.port ? 32'd2 : 32'd1);
            chk("ack_latency", 32'(cyc - ccyc), cur.tmo ? 32'(TO + 1) : 32'(2 + cur.d + cur.h));
            chk("ack_timeout_err", 32'(timeout_err), 32'(cur.exp_te));
            chk("ack_rd_d", cur.port ? p1_rd_d : p0_rd_d, cur.exp_rd);
            chk("hold_addr", addr, cur.addr);
            chk("hold_wr_d", wr_d, cur.data);
            chk("hold_mem_or_reg", 32'(mem_or_reg), 32'(cur.rg));
            chk("hold_grant", 32'(grant), 32'(cur.port));
          end
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    chk("rst_p0_rd_d", p0_rd_d, 32'd0);
    chk("rst_p1_rd_d", p1_rd_d, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wr_d", wr_d, 32'd0);
    chk("rst_be", 32'(wr_byte_en), 32'd0);
    chk("rst_mem_or_reg", 32'(mem_or_reg), 32'd0);
    chk("rst_rd_num_dwords", 32'(rd_num_dwords), 32'd1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    txn_t a, b;
    int n, n0, n1;
    rd_m[0] = '0;
    rd_m[1] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    #1 reset = 1'b0;
    @(posedge clk);

    // Plain memory write on port 0 with a long busy window
    s0.push_back(mk(1, 0, 32'h0000_0010, 32'h0102_0304, 4'hF, 0, 8, 0, 32'h5555_AAAA));
    run_batch();

    // Memory read on port 1 returning a known word
    s1.push_back(mk(0, 0, 32'h0000_0FFF, 32'h0, 4'h0, 1, 2, 0, 32'hDEAD_BEEF));
    run_batch();

    // Register-space write on port 0
    s0.push_back(mk(1, 1, 32'h0000_0800, 32'h8F1F_0000, 4'hF, 0, 3, 0, 32'h1234_5678));
    run_batch();

    // Both ports streaming writes back to back
    for (int i = 0; i < 4; i++) begin
      s0.push_back(mk(1, 0, 32'h100 + 32'(i), $urandom, 4'hF, 0, 1, 0, $urandom));
      s1.push_back(mk(1, 0, 32'h200 + 32'(i), $urandom, 4'h3, 0, 1, 0, $urandom));
    end
    run_batch();

    // busy never rises: timeout, then a following request is still served
    s0.push_back(mk(1, 0, 32'h0000_0020, 32'hA5A5_5A5A, 4'hF, 0, 1, 1, 32'h0));
    s1.push_back(mk(0, 0, 32'h0000_0024, 32'h0, 4'h0, 2, 3, 0, 32'h0BAD_F00D));
    run_batch();

    // Random traffic
    for (int k = 0; k < 25; k++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) s0.push_back(rand_txn());
      for (int i = 0; i < n1; i++) s1.push_back(rand_txn());
      run_batch();
    end

    // Reset during WAIT_DONE of a port 1 read; the held request is granted again afterwards
    a = mk(0, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 30, 0, 32'h1111_2222);
    a.r = 25; a.port = 1'b1;
    b = a;
    b.h = 2; b.r = 0; b.rdat = 32'hCAFE_F00D; b.exp_rd = b.rdat; b.exp_te = 1'b0;
    exp_q.push_back(a); exp_q.push_back(b);
    plan_q.push_back(a); plan_q.push_back(b);
    p1_q.push_back(a);
    n = 0;
    while (!mon_infl && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("rst_cmd_seen", 32'(mon_infl), 32'd1);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    check_reset_vals();
    last_m = 1'b1; te_m = 1'b0; rd_m[0] = '0; rd_m[1] = b.rdat;
    wait_done();

    // Post-reset traffic, starting with a tie between the ports
    s0.push_back(rand_txn());
    s1.push_back(rand_txn());
    run_batch();
    for (int k = 0; k < 6; k++) begin
      n0 = $urandom_range(1, 2);
      n1 = $urandom_range(0, 2);
      for (int i = 0; i < n0; i++) s0.push_back(rand_txn());
      for (int i = 0; i < n1; i++) s1.push_back(rand_txn());
      run_batch();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
